// File: rtl/uart_pkg.sv
// Shared constants, select codes and FSM encoding for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] DIV_115200 = 16'd1085;
  localparam logic [CNT_W-1:0] DIV_19200  = 16'd6510;
  localparam logic [CNT_W-1:0] DIV_9600   = 16'd13021;

  localparam logic [1:0] SEL_115200 = 2'b00;
  localparam logic [1:0] SEL_19200  = 2'b01;
  localparam logic [1:0] SEL_9600   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Code 2'b11 is treated as the default 115200 rate.
  function automatic logic [CNT_W-1:0] div_of(input logic [1:0] sel);
    case (sel)
      SEL_19200: return DIV_19200;
      SEL_9600:  return DIV_9600;
      default:   return DIV_115200;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..div-1 and pulses bit_end_o on the last count.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic [W-1:0] div_i,
  output logic         bit_end_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign bit_end_o = !clr_i && (cnt_q == (div_i - W'(1)));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART 8N1 transmitter with per-frame baud selection.
module uart_tx_sched
  import uart_pkg::*;
(
  input  logic       sys_clk_i,
  input  logic       rst_n_tx,
  input  logic [1:0] div_sel_i,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       grant_id_o
);

  state_e           state_q, state_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic             armed_q;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic             bit_end;
  logic             winner;
  logic             hs;

  uart_bit_timer #(.W(CNT_W)) u_timer (
    .clk_i     (sys_clk_i),
    .rst_n_i   (rst_n_tx),
    .clr_i     (state_q == IDLE),
    .div_i     (div_q),
    .bit_end_o (bit_end)
  );

  // A lone requester always wins; on a tie the one not served last wins.
  assign winner       = (req0_valid_i && req1_valid_i) ? !last_q : req1_valid_i;
  assign req0_ready_o = armed_q && (state_q == IDLE) && req0_valid_i && !winner;
  assign req1_ready_o = armed_q && (state_q == IDLE) && req1_valid_i &&  winner;
  assign hs           = req0_ready_o || req1_ready_o;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    div_d   = div_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = START;
        tx_d    = 1'b0;
        data_d  = winner ? req1_data_i : req0_data_i;
        div_d   = div_of(div_sel_i);
        grant_d = winner;
        last_d  = winner;
        idx_d   = '0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
          tx_d  = data_q[idx_q + 3'd1];
        end
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_tx) begin
    if (!rst_n_tx) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      armed_q <= 1'b0;
      data_q  <= '0;
      div_q   <= DIV_115200;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      armed_q <= 1'b1;
      data_q  <= data_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign grant_id_o = grant_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Shared UART transmit scheduler. Two requesters (core, debug) hand bytes in over valid/ready; the block arbitrates round-robin and serialises each accepted byte as an 8N1 frame on tx_o. Bit timing comes from an internal bit-period counter whose divisor is configured per frame from div_sel_i. Single sys_clk_i domain at 125 MHz.

Parameters:
DIV_115200, 1085, sys_clk_i cycles per bit at 115200 baud
DIV_19200, 6510, cycles per bit at 19200 baud
DIV_9600, 13021, cycles per bit at 9600 baud
CNT_W, 16, bit-period counter width; must hold the largest divisor minus 1

Ports:
sys_clk_i  in  1  system clock, 125 MHz
rst_n_tx  in  1  asynchronous, active-low reset
div_sel_i  in  2  baud select: 00=115200, 01=19200, 10=9600, 11=115200
req0_valid_i  in  1  requester 0 byte valid
req0_data_i  in  8  requester 0 byte
req0_ready_o  out  1  requester 0 byte accepted this cycle
req1_valid_i  in  1  requester 1 byte valid
req1_data_i  in  8  requester 1 byte
req1_ready_o  out  1  requester 1 byte accepted this cycle
tx_o  out  1  serial line, idle high
busy_o  out  1  frame in progress
grant_id_o  out  1  requester that owns the current or last frame

Behaviour:
- Reset values: tx_o=1, busy_o=0, grant_id_o=0, req*_ready_o=0, state=IDLE, last_grant=1 (requester 0 wins the first tie), armed=0.
- armed is a register. It sets on the first clock after reset release. Both ready outputs are gated by armed, so neither is high during reset.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - Ready is combinational: reqN_ready_o = armed & IDLE & reqN_valid_i & winner==N.
  - Winner when only one requester is valid: that requester.
  - Winner when both are valid: !last_grant.
  - Handshake completes when valid and ready are both high in the same cycle. On that edge: latch data, latch the divisor from div_sel_i, set grant_id_o and last_grant to the winner, clear the bit counter, go to START.
- START: tx_o=0 for exactly DIV cycles, then go to DATA with bit index 0.
- DATA: tx_o=data[idx], LSB first. Each bit lasts DIV cycles. After idx=7, go to STOP.
- STOP: tx_o=1 for DIV cycles, then go to IDLE.
- tx_o is registered. The start bit's first low cycle is the cycle after the handshake.
- busy_o = (state != IDLE), registered together with the state.
- Frame length is 10*DIV cycles. Back-to-back frames have one IDLE cycle between them, so start bits are spaced 10*DIV+1 cycles apart.
- Bit counter:
  - Counts 0..DIV-1.
  - bit_end is asserted when the count equals DIV-1; the count wraps to 0 on that cycle.
  - The counter is held at 0 while in IDLE.
- div_sel_i is sampled only at the handshake. Changes mid-frame have no effect until the next frame.
- Data inputs are sampled only at the handshake. Changes to valid/data during a frame are ignored. No holding register: ready stays 0 while busy_o=1.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously), tx_o goes high, the frame is discarded, no ready is issued.
- grant_id_o holds its value after the frame ends until the next handshake.

Decomposition:
- uart_pkg holds:
  - the three divisor constants;
  - the div_sel codes (SEL_115200=2'b00, SEL_19200=2'b01, SEL_9600=2'b10);
  - the FSM state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3).
- Sub-module uart_bit_timer: CNT_W counter with a clear input and a divisor input, producing the bit_end pulse. The FSM and arbitration stay in uart_tx_sched.

Test Plan:
1. Reset, div_sel=00, req0 sends 0xA5 -> ready0 high for 1 cycle. tx_o low for 1085 cycles, then 1,0,1,0,0,1,0,1 at 1085 cycles each, then high for 1085. busy_o high for exactly 10850 cycles. grant_id_o=0.
2. Both valid from reset, req0=0x11, req1=0x22, held -> frames ordered req0, req1, req0, req1. grant_id_o alternates 0,1,0,1. Each ready is high exactly once per frame.
3. div_sel=10, send 0x00; switch div_sel=00 at cycle 20000 -> every bit of that frame is 13021 cycles. The next frame uses 1085-cycle bits. div_sel=11 -> 1085-cycle bits.
4. req1 valid continuously at 115200 -> start-bit falling edges 10851 cycles apart. req0_ready_o is never high.
5. Assert rst_n_tx during data bit 3 -> tx_o=1 and busy_o=0 without waiting for a clock edge. Readies are 0 during reset. After release, req0 and req1 both valid -> no ready in the first cycle (armed=0), then req0 is granted.
6. Valid pulsed for 1 cycle while busy_o=1 -> ignored, no ready, no extra frame.
